m6809_bus_master: RTL and testbench

M6809_BUS_MASTER -- requirements
Module: m6809_bus_master

---
 rtl/system86_pkg.sv | 28 ++
 rtl/m6809_bus_master_if.sv | 35 +++
 rtl/m6809_eq_clkgen.sv | 31 +++
 rtl/m6809_bus_master.sv | 174 +++++++++++++++++
 tb/tb_m6809_bus_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/system86_pkg.sv
// rtl/system86_pkg.sv - shared bus-state enum, phase constants and default addresses
package system86_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOST   = 2'd1,
        ST_VEC_HI = 2'd2,
        ST_VEC_LO = 2'd3
    } bus_state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam logic [15:0] DEF_VEC_ADDR  = 16'hFFF8;
    localparam logic [15:0] DEF_IDLE_ADDR = 16'hFFFF;

    // Q leads E by one phase: Q high in phases 1-2, E high in phases 2-3.
    function automatic logic phase_q_level(input logic [1:0] ph);
        return (ph == PH1) || (ph == PH2);
    endfunction

    function automatic logic phase_e_level(input logic [1:0] ph);
        return (ph == PH2) || (ph == PH3);
    endfunction

endpackage

// File: rtl/m6809_bus_master_if.sv
// rtl/m6809_bus_master_if.sv - host handshake, bus, interrupt and vector signals of the bus master
interface m6809_bus_master_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        busy;

    logic [15:0] MA;
    logic [7:0]  MD_IN;
    logic [7:0]  MD_OUT;
    logic        MD_OE;
    logic        nMWE;
    logic        E;
    logic        Q;

    logic        nMINT;
    logic        irq_en;
    logic [15:0] vec;
    logic        vec_valid;

    modport master (
        input  req, we, addr, wdata, MD_IN, nMINT, irq_en,
        output ack, rdata, busy, MA, MD_OUT, MD_OE, nMWE, E, Q, vec, vec_valid
    );

    modport slave (
        output req, we, addr, wdata, MD_IN, nMINT, irq_en,
        input  ack, rdata, busy, MA, MD_OUT, MD_OE, nMWE, E, Q, vec, vec_valid
    );

endinterface

// File: rtl/m6809_eq_clkgen.sv
// rtl/m6809_eq_clkgen.sv - free-running 2-bit phase counter producing quadrature E and Q
module m6809_eq_clkgen
    import system86_pkg::*;
(
    input  logic       CLK_6M,
    input  logic       rst,
    output logic [1:0] phase,
    output logic       E,
    output logic       Q
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = phase_q + 2'd1;
    end

    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            phase_q <= PH0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign E     = phase_e_level(phase_q);
    assign Q     = phase_q_level(phase_q);

endmodule

// File: rtl/m6809_bus_master.sv
// rtl/m6809_bus_master.sv - 6809-style bus master: host read/write cycles and interrupt vector fetch
module m6809_bus_master
    import system86_pkg::*;
#(
    parameter logic [15:0] VEC_ADDR  = DEF_VEC_ADDR,
    parameter logic [15:0] IDLE_ADDR = DEF_IDLE_ADDR
)(
    input  logic                      CLK_6M,
    input  logic                      rst,
    m6809_bus_master_if.master        bus
);

    logic [1:0]  phase;
    logic        e_clk;
    logic        q_clk;

    m6809_eq_clkgen u_clkgen (
        .CLK_6M (CLK_6M),
        .rst    (rst),
        .phase  (phase),
        .E      (e_clk),
        .Q      (q_clk)
    );

    bus_state_e  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] vec_q, vec_d;
    logic        ack_q, ack_d;
    logic        vec_valid_q, vec_valid_d;
    logic        armed_q, armed_d;
    logic [1:0]  sync_q;

    logic        irq_pending;
    logic        take_host;

    // sync_q[1] is the synchronised nMINT level; idles high so reset never looks like an interrupt.
    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.nMINT};
        end
    end

    assign irq_pending = !sync_q[1] && bus.irq_en && armed_q;

    always_ff @(posedge CLK_6M or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            hi_q        <= '0;
            rdata_q     <= '0;
            vec_q       <= '0;
            ack_q       <= 1'b0;
            vec_valid_q <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            rdata_q     <= rdata_d;
            vec_q       <= vec_d;
            ack_q       <= ack_d;
            vec_valid_q <= vec_valid_d;
            armed_q     <= armed_d;
        end
    end

    // Cycle selection only happens on the phase-3 edge, so every bus cycle spans phases 0..3.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        hi_d        = hi_q;
        rdata_d     = rdata_q;
        vec_d       = vec_q;
        ack_d       = 1'b0;
        vec_valid_d = 1'b0;
        armed_d     = armed_q | sync_q[1];
        take_host   = 1'b0;

        if (phase == PH3) begin
            case (state_q)
                ST_IDLE, ST_HOST: begin
                    if (state_q == ST_HOST) begin
                        ack_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = bus.MD_IN;
                        end
                    end
                    if (irq_pending) begin
                        state_d = ST_VEC_HI;
                    end else if (bus.req) begin
                        take_host = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_VEC_HI: begin
                    hi_d    = bus.MD_IN;
                    state_d = ST_VEC_LO;
                end
                ST_VEC_LO: begin
                    // armed still reads 1 here; the disarm takes effect from this edge on.
                    vec_d       = {hi_q, bus.MD_IN};
                    vec_valid_d = 1'b1;
                    armed_d     = 1'b0;
                    if (bus.req) begin
                        take_host = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (take_host) begin
                state_d = ST_HOST;
                addr_d  = bus.addr;
                we_d    = bus.we;
                wdata_d = bus.wdata;
            end
        end
    end

    logic [15:0] ma;
    logic [7:0]  md_out;
    logic        md_oe;
    logic        n_mwe;

    always_comb begin
        ma     = IDLE_ADDR;
        md_out = '0;
        md_oe  = 1'b0;
        n_mwe  = 1'b1;
        case (state_q)
            ST_HOST: begin
                ma = addr_q;
                if (we_q) begin
                    md_out = wdata_q;
                    md_oe  = (phase != PH0);
                    n_mwe  = !((phase == PH2) || (phase == PH3));
                end
            end
            ST_VEC_HI: ma = VEC_ADDR;
            ST_VEC_LO: ma = VEC_ADDR + 16'd1;
            default:   ma = IDLE_ADDR;
        endcase
    end

    assign bus.MA        = ma;
    assign bus.MD_OUT    = md_out;
    assign bus.MD_OE     = md_oe;
    assign bus.nMWE      = n_mwe;
    assign bus.E         = e_clk;
    assign bus.Q         = q_clk;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;

endmodule

// File: tb/tb_m6809_bus_master.sv
// tb/tb_m6809_bus_master.sv - scoreboard bench for m6809_bus_master
module tb_m6809_bus_master;

    logic CLK_6M = 1'b0;
    logic rst    = 1'b0;

    m6809_bus_master_if bus();

    m6809_bus_master #(
        .VEC_ADDR  (16'hFFF8),
        .IDLE_ADDR (16'hFFFF)
    ) dut (
        .CLK_6M (CLK_6M),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 CLK_6M = ~CLK_6M;

    typedef struct {
        int         cyc;
        logic       rd;
        logic [7:0] data;
    } ack_exp_t;

    ack_exp_t    ack_q[$];
    logic [15:0] vec_q[$];

    int n_vec    = 0;
    int n_miss   = 0;
    int cyc      = 0;
    int vv_count = 0;

    int q1, q2, e1, e2, low, base, vv0;
    logic pq, pe;
    logic [7:0] bb_data [3];

    always @(posedge CLK_6M) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ph();
        if (bus.Q) return bus.E ? 2 : 1;
        else       return bus.E ? 3 : 0;
    endfunction

    task automatic wait_phase(input int p);
        int k = 0;
        do begin
            @(negedge CLK_6M);
            k++;
        end while (ph() != p && k < 64);
        if (ph() != p) check_eq("timeout_phase", ph(), p);
    endtask

    task automatic wait_ph3_idle();
        int k = 0;
        do begin
            @(negedge CLK_6M);
            k++;
        end while (!(ph() == 3 && !bus.busy) && k < 200);
        if (bus.busy) check_eq("timeout_idle", bus.busy, 0);
    endtask

    task automatic wait_ma(input logic [15:0] a);
        int k = 0;
        do begin
            @(negedge CLK_6M);
            k++;
        end while (bus.MA !== a && k < 100);
        if (bus.MA !== a) check_eq("timeout_ma", bus.MA, a);
    endtask

    task automatic drain();
        int k = 0;
        while ((ack_q.size() != 0 || vec_q.size() != 0) && k < 100) begin
            @(negedge CLK_6M);
            k++;
        end
        check_eq("drain_ack", ack_q.size(), 0);
        check_eq("drain_vec", vec_q.size(), 0);
    endtask

    always @(negedge CLK_6M) begin : ack_monitor
        ack_exp_t e;
        if (bus.ack) begin
            if (ack_q.size() == 0) begin
                check_eq("ack_unexpected", bus.ack, 0);
            end else begin
                e = ack_q.pop_front();
                check_eq("ack_cycle", cyc, e.cyc);
                if (e.rd) check_eq("rdata", bus.rdata, e.data);
            end
        end
    end

    always @(negedge CLK_6M) begin : vec_monitor
        logic [15:0] v;
        if (bus.vec_valid) begin
            vv_count++;
            if (vec_q.size() == 0) begin
                check_eq("vec_valid_unexpected", bus.vec_valid, 0);
            end else begin
                v = vec_q.pop_front();
                check_eq("vec", bus.vec, v);
            end
        end
    end

    initial begin
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.MD_IN  = '0;
        bus.nMINT  = 1'b1;
        bus.irq_en = 1'b1;
        bb_data    = '{8'h11, 8'h22, 8'h33};

        #2;
        check_eq("rst_ma",     bus.MA, 16'hFFFF);
        check_eq("rst_nmwe",   bus.nMWE, 1);
        check_eq("rst_md_oe",  bus.MD_OE, 0);
        check_eq("rst_md_out", bus.MD_OUT, 0);
        check_eq("rst_e",      bus.E, 0);
        check_eq("rst_q",      bus.Q, 0);
        check_eq("rst_busy",   bus.busy, 0);
        check_eq("rst_ack",    bus.ack, 0);
        check_eq("rst_rdata",  bus.rdata, 0);
        check_eq("rst_vec",    bus.vec, 0);
        check_eq("rst_vv",     bus.vec_valid, 0);
        repeat (3) @(negedge CLK_6M);
        rst = 1'b1;

        // free-run E/Q timing
        q1 = -1; q2 = -1; e1 = -1; e2 = -1; pq = bus.Q; pe = bus.E;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK_6M);
            if (bus.Q && !pq) begin
                if (q1 < 0) q1 = cyc; else if (q2 < 0) q2 = cyc;
            end
            if (bus.E && !pe) begin
                if (e1 < 0) e1 = cyc; else if (e2 < 0) e2 = cyc;
            end
            pq = bus.Q;
            pe = bus.E;
        end
        check_eq("q_period", q2 - q1, 4);
        check_eq("e_period", e2 - e1, 4);
        check_eq("q_leads_e", e1 - q1, 1);
        check_eq("idle_ma", bus.MA, 16'hFFFF);

        // host write 2000 <- A5
        wait_ph3_idle();
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h2000; bus.wdata = 8'hA5;
        ack_q.push_back('{cyc: cyc + 5, rd: 1'b0, data: 8'h00});
        low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_6M);
            if (i == 0) bus.req = 1'b0;
            check_eq("wr_ma", bus.MA, 16'h2000);
            check_eq("wr_md_out", bus.MD_OUT, 8'hA5);
            check_eq("wr_md_oe", bus.MD_OE, (i != 0));
            check_eq("wr_nmwe", bus.nMWE, (i < 2));
            if (!bus.nMWE) low++;
        end
        check_eq("wr_nmwe_low_cnt", low, 2);
        drain();

        // host read 4000 -> 3C
        wait_ph3_idle();
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h4000; bus.MD_IN = 8'h3C;
        ack_q.push_back('{cyc: cyc + 5, rd: 1'b1, data: 8'h3C});
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_6M);
            if (i == 0) bus.req = 1'b0;
            check_eq("rd_ma", bus.MA, 16'h4000);
            check_eq("rd_nmwe", bus.nMWE, 1);
            check_eq("rd_md_oe", bus.MD_OE, 0);
        end
        drain();

        // three back-to-back reads with req held
        wait_ph3_idle();
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h1000;
        base = cyc + 1;
        for (int k = 0; k < 3; k++)
            ack_q.push_back('{cyc: base + 4 * (k + 1), rd: 1'b1, data: bb_data[k]});
        for (int k = 0; k < 3; k++) begin
            repeat ((k == 0) ? 1 : 4) @(negedge CLK_6M);
            check_eq("b2b_ma", bus.MA, 16'h1000 + 16'(k));
            check_eq("b2b_busy", bus.busy, 1);
            bus.MD_IN = bb_data[k];
            bus.addr  = 16'h1000 + 16'(k + 1);
            if (k == 2) bus.req = 1'b0;
        end
        drain();

        // interrupt vector fetch, one fetch per assertion
        wait_ph3_idle();
        vv0 = vv_count;
        bus.nMINT = 1'b0;
        bus.MD_IN = 8'h12;
        vec_q.push_back(16'h1234);
        wait_ma(16'hFFF8);
        check_eq("irq_hi_phase", ph(), 0);
        check_eq("irq_busy", bus.busy, 1);
        wait_ma(16'hFFF9);
        check_eq("irq_lo_phase", ph(), 0);
        bus.MD_IN = 8'h34;
        drain();
        repeat (100) @(negedge CLK_6M);
        check_eq("irq_single_fetch", vv_count - vv0, 1);
        check_eq("irq_idle_after", bus.busy, 0);
        bus.nMINT = 1'b1;
        repeat (8) @(negedge CLK_6M);

        // interrupt and request on the same edge; irq_en dropped mid-fetch
        wait_ph3_idle();
        wait_phase(0);
        bus.nMINT = 1'b0;
        bus.MD_IN = 8'h56;
        wait_phase(3);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h5000;
        base = cyc + 1;
        ack_q.push_back('{cyc: base + 12, rd: 1'b1, data: 8'h9A});
        vec_q.push_back(16'h5656);
        wait_ma(16'hFFF8);
        check_eq("prio_vec_start", cyc, base);
        bus.irq_en = 1'b0;
        wait_ma(16'h5000);
        check_eq("prio_host_start", cyc, base + 8);
        bus.MD_IN = 8'h9A;
        bus.req   = 1'b0;
        bus.nMINT = 1'b1;
        drain();
        bus.irq_en = 1'b1;

        // reset in phase 2 of a write
        wait_ph3_idle();
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h6000; bus.wdata = 8'h77;
        wait_phase(2);
        check_eq("mid_pre_nmwe", bus.nMWE, 0);
        check_eq("mid_pre_md_oe", bus.MD_OE, 1);
        bus.req = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_nmwe", bus.nMWE, 1);
        check_eq("mid_rst_md_oe", bus.MD_OE, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_ma", bus.MA, 16'hFFFF);
        check_eq("mid_rst_rdata", bus.rdata, 0);
        check_eq("mid_rst_vec", bus.vec, 0);
        repeat (3) @(negedge CLK_6M);
        rst = 1'b1;
        #1;
        check_eq("rel_e", bus.E, 0);
        check_eq("rel_q", bus.Q, 0);
        @(negedge CLK_6M);
        check_eq("rel_ph1", ph(), 1);
        repeat (10) @(negedge CLK_6M);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
